slope_div19: RTL and testbench

SLOPE_DIV19 -- requirements
Module: slope_div19

---
 rtl/slope_div_pkg.sv | 7 +
 rtl/slope_div19_addsub20.sv | 11 +
 rtl/slope_div19.sv | 88 ++++++++
 tb/tb_slope_div19.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/slope_div_pkg.sv
// slope_div_pkg: shared widths, state encoding and constants for the slope divider
package slope_div_pkg;
  localparam int DIV_W = 19;
  localparam int CNT_W = 5;
  localparam logic [DIV_W-1:0] DBZ_Q = '1;
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
endpackage

// File: rtl/slope_div19_addsub20.sv
// addsub20: combinational add/subtract; sub inverts b and supplies the carry-in
module addsub20 #(
  parameter int W = 20
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic [W-1:0] y
);
  assign y = a + (b ^ {W{sub}}) + {{(W-1){1'b0}}, sub};
endmodule

// File: rtl/slope_div19.sv
// slope_div19: multi-cycle unsigned non-restoring divider with valid/ready handshakes
module slope_div19 #(
  parameter int DIV_W = slope_div_pkg::DIV_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DIV_W-1:0] dividend,
  input  logic [DIV_W-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DIV_W-1:0] quotient,
  output logic [DIV_W-1:0] remainder,
  output logic             div_by_zero
);
  import slope_div_pkg::*;
  state_t state, nxt;
  logic [CNT_W-1:0] cnt;
  logic [DIV_W:0] pr, opa, sum;
  logic [DIV_W-1:0] dvd, dvs, q;
  logic sub, accept, last;
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  assign accept = in_valid && in_ready;
  assign last = cnt == CNT_W'(DIV_W - 1);
  // CALC shifts in the next dividend bit and picks the op from the old sign; FIX only ever adds back
  assign opa = state == CALC ? {pr[DIV_W-1:0], dvd[DIV_W-1]} : pr;
  assign sub = state == CALC && !pr[DIV_W];
  addsub20 #(.W(DIV_W + 1)) u_addsub (
    .a  (opa),
    .b  ({1'b0, dvs}),
    .sub(sub),
    .y  (sum)
  );
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (accept) nxt = divisor == '0 ? DONE : CALC;
      CALC:    if (last) nxt = FIX;
      FIX:     nxt = DONE;
      DONE:    if (out_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      pr          <= '0;
      dvd         <= '0;
      dvs         <= '0;
      q           <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          dvd <= dividend;
          dvs <= divisor;
          pr  <= '0;
          cnt <= '0;
          q   <= '0;
          if (divisor == '0) begin
            quotient    <= '1;
            remainder   <= dividend;
            div_by_zero <= 1'b1;
          end
        end
        CALC: begin
          pr  <= sum;
          dvd <= dvd << 1;
          q   <= {q[DIV_W-2:0], ~sum[DIV_W]};
          cnt <= cnt + 1'b1;
        end
        FIX: begin
          quotient    <= q;
          remainder   <= pr[DIV_W] ? sum[DIV_W-1:0] : pr[DIV_W-1:0];
          div_by_zero <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_slope_div19.sv
// tb_slope_div19: directed table, handshake/reset sequences and randomized check against arithmetic model
module tb_slope_div19;
  logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 0;
  logic [18:0] dividend = '0, divisor = '0;
  logic in_ready, out_valid, div_by_zero;
  logic [18:0] quotient, remainder;
  int errors = 0, checks = 0;

  slope_div19 dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor), .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [18:0] dd, dv, eq, er;
    logic ez;
    int hold;
    bit early;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic do_div(input logic [18:0] dd, input logic [18:0] dv, input int hold, input bit early,
                        output logic [18:0] q, output logic [18:0] r, output logic z, output int lat);
    int n = 0;
    while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
    chk("in_ready_before_accept", in_ready, 1);
    dividend = dd; divisor = dv; in_valid = 1; out_ready = early;
    @(posedge clk); #1;
    dividend = 19'($urandom); divisor = 19'($urandom);
    lat = 0;
    while (!out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    in_valid = 0;
    q = quotient; r = remainder; z = div_by_zero;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_out_valid", out_valid, 1);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_stable", {quotient, remainder, div_by_zero}, {q, r, z});
    end
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    chk("release_out_valid", out_valid, 0);
    chk("release_in_ready", in_ready, 1);
  endtask

  function automatic void model(input logic [18:0] dd, input logic [18:0] dv,
                                output logic [18:0] q, output logic [18:0] r, output logic z);
    int unsigned a = dd, b = dv;
    z = (b == 0);
    q = z ? 19'h7FFFF : 19'(a / b);
    r = z ? dd : 19'(a % b);
  endfunction

  function automatic logic [18:0] pick();
    case ($urandom_range(0, 5))
      0: return 19'd0;
      1: return 19'd1;
      2: return 19'h7FFFF;
      3: return 19'($urandom_range(0, 31));
      default: return 19'($urandom);
    endcase
  endfunction

  initial begin
    vec_t vt[10];
    logic [18:0] q, r, eq, er;
    logic z, ez;
    int lat;
    vt[0] = '{19'd100, 19'd7, 19'd14, 19'd2, 1'b0, 0, 1'b0};
    vt[1] = '{19'h7FFFF, 19'd1, 19'h7FFFF, 19'd0, 1'b0, 0, 1'b0};
    vt[2] = '{19'd3, 19'd10, 19'd0, 19'd3, 1'b0, 0, 1'b1};
    vt[3] = '{19'd5, 19'd0, 19'h7FFFF, 19'd5, 1'b1, 2, 1'b0};
    vt[4] = '{19'd0, 19'd5, 19'd0, 19'd0, 1'b0, 0, 1'b0};
    vt[5] = '{19'd0, 19'd0, 19'h7FFFF, 19'd0, 1'b1, 0, 1'b1};
    vt[6] = '{19'h7FFFF, 19'h7FFFF, 19'd1, 19'd0, 1'b0, 0, 1'b0};
    vt[7] = '{19'h7FFFE, 19'h7FFFF, 19'd0, 19'h7FFFE, 1'b0, 0, 1'b0};
    vt[8] = '{19'd1000, 19'd3, 19'd333, 19'd1, 1'b0, 10, 1'b0};
    vt[9] = '{19'h40000, 19'd2, 19'h20000, 19'd0, 1'b0, 0, 1'b1};

    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_outputs", {quotient, remainder, div_by_zero}, 0);
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;

    foreach (vt[i]) begin
      do_div(vt[i].dd, vt[i].dv, vt[i].hold, vt[i].early, q, r, z, lat);
      chk($sformatf("vec%0d_quotient", i), q, vt[i].eq);
      chk($sformatf("vec%0d_remainder", i), r, vt[i].er);
      chk($sformatf("vec%0d_dbz", i), z, vt[i].ez);
      chk($sformatf("vec%0d_latency", i), lat, vt[i].dv == 0 ? 0 : 20);
    end

    // reset in the middle of a division, then a fresh 100/7 right after release
    dividend = 19'd100; divisor = 19'd7; in_valid = 1;
    @(posedge clk); #1; in_valid = 0;
    repeat (7) @(posedge clk);
    #2 rst_n = 0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    @(negedge clk); rst_n = 1;
    do_div(19'd100, 19'd7, 0, 1'b0, q, r, z, lat);
    chk("postrst_quotient", q, 14);
    chk("postrst_remainder", r, 2);
    chk("postrst_latency", lat, 20);

    // reset while a divide-by-zero result is waiting in DONE
    dividend = 19'd5; divisor = 19'd0; in_valid = 1;
    @(posedge clk); #1; in_valid = 0;
    chk("done_before_rst", out_valid, 1);
    #2 rst_n = 0;
    #1;
    chk("donerst_out_valid", out_valid, 0);
    chk("donerst_outputs", {quotient, remainder, div_by_zero}, 0);
    @(negedge clk); rst_n = 1;

    for (int i = 0; i < 1500; i++) begin
      logic [18:0] dd, dv;
      dd = pick(); dv = pick();
      do_div(dd, dv, 0, 1'($urandom), q, r, z, lat);
      model(dd, dv, eq, er, ez);
      chk("rnd_result", {q, r, z}, {eq, er, ez});
      chk("rnd_latency", lat, dv == 0 ? 0 : 20);
      if (dv != 0) begin
        chk("rnd_identity", 38'(q) * 38'(dv) + 38'(r) == 38'(dd) && r < dv, 1);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
